// File: rtl/jesd204b_lmfc_tracker_if.sv
// Control/status bundle of jesd204b_lmfc_tracker (SYSREF inputs, LMFC outputs).
// o_err_cnt is present only when JESD_LMFC_ERR_CNT_EN is defined.
interface jesd204b_lmfc_tracker_if #(
  parameter int CNT_W        = 3,
  parameter int MF_CNT_WIDTH = 8
);
  logic                    sysref;
  logic                    sysref_mode;
  logic                    sysref_rearm;
  logic [CNT_W-1:0]        lmfc_offset;
  logic                    o_lmfc;
  logic [CNT_W-1:0]        o_lmfc_cnt;
  logic [MF_CNT_WIDTH-1:0] o_mf_cnt;
  logic                    o_aligned;
  logic                    o_sysref_err;
`ifdef JESD_LMFC_ERR_CNT_EN
  logic [7:0]              o_err_cnt;
`endif

  modport master (
    output sysref, sysref_mode, sysref_rearm, lmfc_offset,
    input  o_lmfc, o_lmfc_cnt, o_mf_cnt, o_aligned, o_sysref_err
`ifdef JESD_LMFC_ERR_CNT_EN
    , input o_err_cnt
`endif
  );

  modport slave (
    input  sysref, sysref_mode, sysref_rearm, lmfc_offset,
    output o_lmfc, o_lmfc_cnt, o_mf_cnt, o_aligned, o_sysref_err
`ifdef JESD_LMFC_ERR_CNT_EN
    , output o_err_cnt
`endif
  );
endinterface

// File: rtl/jesd204b_lmfc_tracker.sv
// LMFC generator aligned to SYSREF with one-shot/continuous modes and phase check.
// Define JESD_LMFC_ERR_CNT_EN to add the saturating SYSREF error counter o_err_cnt.
module jesd204b_lmfc_tracker #(
  parameter int JESD_F         = 1,
  parameter int JESD_K         = 32,
  parameter int OCTETS_PER_CLK = 4,
  parameter int MF_CNT_WIDTH   = 8,
  localparam int P             = (JESD_K * JESD_F) / OCTETS_PER_CLK,
  localparam int CNT_W         = (P > 1) ? $clog2(P) : 1
) (
  input  logic                   dclk,
  input  logic                   rst,
  jesd204b_lmfc_tracker_if.slave lmfc_bus
);

  generate
    if (((JESD_K * JESD_F) % OCTETS_PER_CLK) != 0 || P < 2) begin : g_bad_p
      $error("jesd204b_lmfc_tracker: JESD_K*JESD_F/OCTETS_PER_CLK must be an integer >= 2");
    end
  endgenerate

  // One extra bit so an offset equal to 2^CNT_W-1 can still be compared against P.
  localparam logic [CNT_W:0]   P_EXT  = (CNT_W + 1)'(P);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P - 1);

  typedef enum logic {
    WAIT_SYSREF = 1'b0,
    ALIGNED     = 1'b1
  } state_t;

  state_t                  state_reg;
  logic                    sysref_r1_reg;
  logic                    sysref_r2_reg;
  logic [CNT_W-1:0]        lmfc_cnt_reg;
  logic [MF_CNT_WIDTH-1:0] mf_cnt_reg;
  logic                    aligned_reg;
  logic                    sysref_err_reg;

  logic                    sysref_edge;
  logic                    cnt_wrap;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        offset_eff;

  always_comb begin
    sysref_edge = sysref_r1_reg & ~sysref_r2_reg;
    cnt_wrap    = (lmfc_cnt_reg == P_LAST);
    cnt_next    = cnt_wrap ? '0 : lmfc_cnt_reg + CNT_W'(1);
    offset_eff  = ({1'b0, lmfc_bus.lmfc_offset} >= P_EXT) ? '0 : lmfc_bus.lmfc_offset;
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_reg      <= WAIT_SYSREF;
      sysref_r1_reg  <= 1'b0;
      sysref_r2_reg  <= 1'b0;
      lmfc_cnt_reg   <= '0;
      mf_cnt_reg     <= '0;
      aligned_reg    <= 1'b0;
      sysref_err_reg <= 1'b0;
    end else begin
      sysref_r1_reg  <= lmfc_bus.sysref;
      sysref_r2_reg  <= sysref_r1_reg;
      sysref_err_reg <= 1'b0;
      lmfc_cnt_reg   <= cnt_next;
      if (cnt_wrap) begin
        mf_cnt_reg <= mf_cnt_reg + MF_CNT_WIDTH'(1);
      end
      // Alignment loads below override the free-running updates above.
      case (state_reg)
        WAIT_SYSREF: begin
          if (sysref_edge) begin
            lmfc_cnt_reg <= offset_eff;
            mf_cnt_reg   <= '0;
            aligned_reg  <= 1'b1;
            state_reg    <= ALIGNED;
          end
        end
        ALIGNED: begin
          if (sysref_edge && lmfc_bus.sysref_rearm) begin
            lmfc_cnt_reg <= offset_eff;
            mf_cnt_reg   <= '0;
          end else if (sysref_edge) begin
            if (lmfc_bus.sysref_mode && (cnt_next != offset_eff)) begin
              lmfc_cnt_reg   <= offset_eff;
              mf_cnt_reg     <= '0;
              sysref_err_reg <= 1'b1;
            end
          end else if (lmfc_bus.sysref_rearm) begin
            aligned_reg <= 1'b0;
            state_reg   <= WAIT_SYSREF;
          end
        end
      endcase
    end
  end

`ifdef JESD_LMFC_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Counts the registered error pulse, so a pulse visible during a rearm survives as 1.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= 8'd0;
    end else if (lmfc_bus.sysref_rearm) begin
      err_cnt_reg <= {7'd0, sysref_err_reg};
    end else if (sysref_err_reg && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign lmfc_bus.o_err_cnt = err_cnt_reg;
`endif

  assign lmfc_bus.o_lmfc       = aligned_reg & (lmfc_cnt_reg == '0);
  assign lmfc_bus.o_lmfc_cnt   = lmfc_cnt_reg;
  assign lmfc_bus.o_mf_cnt     = mf_cnt_reg;
  assign lmfc_bus.o_aligned    = aligned_reg;
  assign lmfc_bus.o_sysref_err = sysref_err_reg;

endmodule

// File: tb/tb_jesd204b_lmfc_tracker.sv
// Randomised self-checking bench: three tracker instances (P=16, 20, 2) share SYSREF
// stimulus and are compared every cycle against a phase/anchor reference model.
`timescale 1ns/1ps
module tb_jesd204b_lmfc_tracker;
  localparam int NI = 3;

  logic       dclk;
  logic       rst;
  logic       sysref;
  logic       mode;
  logic       rearm;
  logic [3:0] off16;
  logic [4:0] off20;
  logic [0:0] off2;

  int n_tests;
  int n_fail;

  // Model: counter value = (anchor value + cycles since anchor) mod P.
  int m_t;
  int m_anchor_t [NI];
  int m_anchor_v [NI];
  bit m_aligned  [NI];
  bit m_err      [NI];
  int m_errcnt   [NI];
  bit m_s1;
  bit m_s2;

  jesd204b_lmfc_tracker_if #(.CNT_W(4), .MF_CNT_WIDTH(8)) bus16 ();
  jesd204b_lmfc_tracker_if #(.CNT_W(5), .MF_CNT_WIDTH(8)) bus20 ();
  jesd204b_lmfc_tracker_if #(.CNT_W(1), .MF_CNT_WIDTH(8)) bus2 ();

  jesd204b_lmfc_tracker #(.JESD_F(1), .JESD_K(64), .OCTETS_PER_CLK(4), .MF_CNT_WIDTH(8))
    u_dut16 (.dclk(dclk), .rst(rst), .lmfc_bus(bus16));
  jesd204b_lmfc_tracker #(.JESD_F(4), .JESD_K(20), .OCTETS_PER_CLK(4), .MF_CNT_WIDTH(8))
    u_dut20 (.dclk(dclk), .rst(rst), .lmfc_bus(bus20));
  jesd204b_lmfc_tracker #(.JESD_F(1), .JESD_K(8), .OCTETS_PER_CLK(4), .MF_CNT_WIDTH(8))
    u_dut2 (.dclk(dclk), .rst(rst), .lmfc_bus(bus2));

  assign bus16.sysref = sysref;
  assign bus20.sysref = sysref;
  assign bus2.sysref  = sysref;
  assign bus16.sysref_mode = mode;
  assign bus20.sysref_mode = mode;
  assign bus2.sysref_mode  = mode;
  assign bus16.sysref_rearm = rearm;
  assign bus20.sysref_rearm = rearm;
  assign bus2.sysref_rearm  = rearm;
  assign bus16.lmfc_offset = off16;
  assign bus20.lmfc_offset = off20;
  assign bus2.lmfc_offset  = off2;

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  function automatic int p_of(int i);
    case (i)
      0:       return 16;
      1:       return 20;
      default: return 2;
    endcase
  endfunction

  function automatic int off_of(int i);
    case (i)
      0:       return int'(off16);
      1:       return int'(off20);
      default: return int'(off2);
    endcase
  endfunction

  task automatic model_reset();
    m_t  = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_anchor_t[i] = 0;
      m_anchor_v[i] = 0;
      m_aligned[i]  = 1'b0;
      m_err[i]      = 1'b0;
      m_errcnt[i]   = 0;
    end
  endtask

  task automatic model_edge();
    bit sys_edge;
    sys_edge = m_s1 && !m_s2;
    m_s2 = m_s1;
    m_s1 = sysref;
    m_t++;
    for (int i = 0; i < NI; i++) begin
      bit prev_err;
      int eff;
      int nxt;
      prev_err = m_err[i];
      eff = (off_of(i) >= p_of(i)) ? 0 : off_of(i);
      nxt = (m_anchor_v[i] + (m_t - m_anchor_t[i])) % p_of(i);
      m_err[i] = 1'b0;
      if (sys_edge) begin
        if (!m_aligned[i] || rearm || (mode && nxt != eff)) begin
          if (m_aligned[i] && !rearm) m_err[i] = 1'b1;
          m_anchor_t[i] = m_t;
          m_anchor_v[i] = eff;
          m_aligned[i]  = 1'b1;
        end
      end else if (rearm) begin
        m_aligned[i] = 1'b0;
      end
      if (rearm) m_errcnt[i] = prev_err ? 1 : 0;
      else if (prev_err && m_errcnt[i] < 255) m_errcnt[i]++;
    end
  endtask

  function automatic logic [26:0] exp_vec(int i);
    int   ph;
    int   cnt;
    int   mf;
    int   ec;
    logic lm;
    ph  = m_anchor_v[i] + (m_t - m_anchor_t[i]);
    cnt = ph % p_of(i);
    mf  = (ph / p_of(i)) % 256;
    lm  = m_aligned[i] && (cnt == 0);
`ifdef JESD_LMFC_ERR_CNT_EN
    ec  = m_errcnt[i];
`else
    ec  = 0;
`endif
    return {ec[7:0], lm, m_aligned[i], m_err[i], mf[7:0], cnt[7:0]};
  endfunction

  function automatic logic [26:0] act_vec(int i);
    logic [7:0] ec;
    ec = 8'd0;
    case (i)
      0: begin
`ifdef JESD_LMFC_ERR_CNT_EN
        ec = bus16.o_err_cnt;
`endif
        return {ec, bus16.o_lmfc, bus16.o_aligned, bus16.o_sysref_err, bus16.o_mf_cnt,
                4'd0, bus16.o_lmfc_cnt};
      end
      1: begin
`ifdef JESD_LMFC_ERR_CNT_EN
        ec = bus20.o_err_cnt;
`endif
        return {ec, bus20.o_lmfc, bus20.o_aligned, bus20.o_sysref_err, bus20.o_mf_cnt,
                3'd0, bus20.o_lmfc_cnt};
      end
      default: begin
`ifdef JESD_LMFC_ERR_CNT_EN
        ec = bus2.o_err_cnt;
`endif
        return {ec, bus2.o_lmfc, bus2.o_aligned, bus2.o_sysref_err, bus2.o_mf_cnt,
                7'd0, bus2.o_lmfc_cnt};
      end
    endcase
  endfunction

  // Advance one dclk edge; the model sees the same pre-edge inputs as the DUTs.
  task automatic step();
    @(posedge dclk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      sysref = ~sysref;
      step();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    sysref = 1'b0;
    rst    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL post_reset dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    $display("[TB] test_reset: reset held 3 cycles, released, 10 idle cycles");
  endtask

  task automatic test_oneshot_align();
    int first_lmfc;
    mode  = 1'b0;
    off16 = 4'd2;
    off20 = 5'($urandom_range(0, 19));
    off2  = 1'($urandom);
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    step();
    n_tests++;
    if (bus16.o_lmfc_cnt !== 4'd2 || bus16.o_aligned !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_load: cnt=%0d aligned=%b want cnt=2 aligned=1",
               bus16.o_lmfc_cnt, bus16.o_aligned);
    end
    first_lmfc = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (first_lmfc < 0 && bus16.o_lmfc === 1'b1) first_lmfc = c;
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL oneshot dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (first_lmfc != 14) begin
      n_fail++;
      $display("FAIL oneshot_first_lmfc: cycles after load=%0d want 14", first_lmfc);
    end
    $display("[TB] test_oneshot_align: offsets %0d/%0d/%0d, first lmfc after %0d",
             off16, off20, off2, first_lmfc);
  endtask

  task automatic test_oneshot_ignore();
    int errs;
    errs = 0;
    for (int c = 0; c < 48; c++) begin
      sysref = (c == 21);
      step();
      if (bus16.o_sysref_err === 1'b1) errs++;
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL oneshot_ignore dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL oneshot_ignore_err: pulses=%0d want 0", errs);
    end
    $display("[TB] test_oneshot_ignore: off-phase sysref in one-shot mode");
  endtask

  task automatic test_continuous();
    int errs;
    errs  = 0;
    mode  = 1'b1;
    off16 = 4'd2;
    for (int per = 0; per < 4; per++) begin
      for (int c = 0; c < 32; c++) begin
        sysref = (c == 0);
        step();
        if (per > 0 && bus16.o_sysref_err === 1'b1) errs++;
        for (int i = 0; i < NI; i++) begin
          n_tests++;
          if (act_vec(i) !== exp_vec(i)) begin
            n_fail++;
            $display("FAIL cont dut%0d per%0d cyc%0d: got %h want %h", i, per, c, act_vec(i), exp_vec(i));
          end
        end
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL cont_inphase_err: pulses=%0d want 0", errs);
    end
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      sysref = (c == 3);
      step();
      if (bus16.o_sysref_err === 1'b1) errs++;
      if (c == 4) begin
        n_tests++;
        if (bus16.o_sysref_err !== 1'b1 || bus16.o_lmfc_cnt !== 4'd2 || bus16.o_mf_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL cont_shift_load: err=%b cnt=%0d mf=%0d want err=1 cnt=2 mf=0",
                   bus16.o_sysref_err, bus16.o_lmfc_cnt, bus16.o_mf_cnt);
        end
      end
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL cont_shift dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (errs != 1) begin
      n_fail++;
      $display("FAIL cont_shift_err: pulses=%0d want 1", errs);
    end
    $display("[TB] test_continuous: 4 in-phase periods then one +3 shifted sysref");
  endtask

  task automatic test_rearm();
    int lmfc_seen;
    int wait_cyc;
    lmfc_seen = 0;
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    n_tests++;
    if (bus16.o_aligned !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_clear: aligned=%b want 0", bus16.o_aligned);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus16.o_lmfc === 1'b1) lmfc_seen++;
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL rearm_idle dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (lmfc_seen != 0) begin
      n_fail++;
      $display("FAIL rearm_lmfc_suppress: pulses=%0d want 0", lmfc_seen);
    end
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    mode = 1'b1;
    wait_cyc = $urandom_range(3, 10);
    for (int c = 0; c < wait_cyc; c++) step();
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    rearm  = 1'b1;
    step();
    rearm  = 1'b0;
    n_tests++;
    if (bus16.o_aligned !== 1'b1 || bus16.o_sysref_err !== 1'b0 || bus16.o_lmfc_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL rearm_edge: aligned=%b err=%b cnt=%0d want aligned=1 err=0 cnt=2",
               bus16.o_aligned, bus16.o_sysref_err, bus16.o_lmfc_cnt);
    end
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (act_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL rearm_edge dut%0d: got %h want %h", i, act_vec(i), exp_vec(i));
      end
    end
    $display("[TB] test_rearm: rearm alone, then rearm with edge after %0d cycles", wait_cyc);
  endtask

  task automatic test_offset_boundary();
    logic [4:0] offs [3];
    offs[0] = 5'd20;
    offs[1] = 5'd19;
    offs[2] = 5'd31;
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      off20 = offs[k];
      rearm = 1'b1;
      step();
      rearm = 1'b0;
      sysref = 1'b1;
      step();
      sysref = 1'b0;
      step();
      n_tests++;
      if (bus20.o_lmfc_cnt !== ((offs[k] >= 5'd20) ? 5'd0 : offs[k])) begin
        n_fail++;
        $display("FAIL offset_load off=%0d: cnt=%0d", offs[k], bus20.o_lmfc_cnt);
      end
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL offset dut%0d off=%0d: got %h want %h", i, offs[k], act_vec(i), exp_vec(i));
        end
      end
      $display("[TB] test_offset_boundary: offset %0d loaded as %0d", offs[k], bus20.o_lmfc_cnt);
    end
  endtask

  task automatic test_held_high();
    int loads;
    int errs;
    bit prev_al;
    loads = 0;
    errs  = 0;
    mode  = 1'b1;
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    prev_al = bus16.o_aligned;
    sysref = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!prev_al && bus16.o_aligned === 1'b1) loads++;
      prev_al = bus16.o_aligned;
      if (bus16.o_sysref_err === 1'b1 || bus20.o_sysref_err === 1'b1 || bus2.o_sysref_err === 1'b1) errs++;
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL held dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    sysref = 1'b0;
    n_tests++;
    if (loads != 1 || errs != 0) begin
      n_fail++;
      $display("FAIL held_single_align: loads=%0d errs=%0d want 1/0", loads, errs);
    end
    $display("[TB] test_held_high: sysref high 40 cycles");
  endtask

  task automatic test_p2_sweep();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus2.o_lmfc === 1'b1) pulses++;
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL p2 dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (pulses != 10) begin
      n_fail++;
      $display("FAIL p2_rate: pulses=%0d in 20 cycles want 10", pulses);
    end
    $display("[TB] test_p2_sweep: %0d lmfc pulses in 20 cycles", pulses);
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 7; c++) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (act_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got %h want %h", i, act_vec(i), exp_vec(i));
      end
    end
    for (int c = 0; c < 3; c++) begin
      sysref = ~sysref;
      step();
    end
    sysref = 1'b0;
    rst    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL async_release dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    $display("[TB] test_async_reset: mid-multiframe reset, 12 cycles after release");
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rearm = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 299) == 0) begin
        off16 = 4'($urandom);
        off20 = 5'($urandom);
        off2  = 1'($urandom);
      end
      if ($urandom_range(0, 19) == 0) sysref = ~sysref;
      step();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    rearm = 1'b0;
    $display("[TB] test_random: 1500 randomised cycles");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    sysref  = 1'b0;
    mode    = 1'b0;
    rearm   = 1'b0;
    off16   = 4'd2;
    off20   = 5'd5;
    off2    = 1'b1;
    model_reset();
    test_reset();
    test_oneshot_align();
    test_oneshot_ignore();
    test_continuous();
    test_rearm();
    test_offset_boundary();
    test_held_high();
    test_p2_sweep();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
